// File: rtl/vram_brush_writer.sv
// vram_brush_writer: clears the frame buffer and stamps a square brush around each new touch point.
module vram_brush_writer #(
  parameter int DISPLAY_WIDTH = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int BRUSH = 3,
  localparam int VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  localparam int A = $clog2(VRAM_L)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         touch_valid,
  input  logic [8:0]   touch_x,
  input  logic [8:0]   touch_y,
  input  logic         clear_req,
  input  logic [15:0]  clear_color,
  input  logic [15:0]  draw_color,
  output logic         vram_wr_ena,
  output logic [A-1:0] vram_wr_addr,
  output logic [15:0]  vram_wr_data,
  output logic         busy
);
  localparam int HALF = (BRUSH - 1) / 2;
  localparam int N = BRUSH * BRUSH;
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PAINT} state_t;
  state_t r_state;
  logic [A:0] r_cnt;
  logic [8:0] r_x, r_y, r_last_x, r_last_y;
  logic r_last_v;
  logic [15:0] r_color;
  logic [3:0] r_dx, r_dy;
  logic [7:0] r_n;
  logic w_idle, w_in, w_wrap, w_accept;
  logic [8:0] w_bx, w_by;
  logic [3:0] w_dx, w_dy, w_ndx, w_ndy;
  logic [11:0] w_px, w_py;
  logic [A-1:0] w_addr;
  // In idle the pixel path evaluates offset (0,0) of the incoming touch so the first write lands one cycle after acceptance
  assign w_idle = r_state == S_IDLE;
  assign w_bx = w_idle ? touch_x : r_x;
  assign w_by = w_idle ? touch_y : r_y;
  assign w_dx = w_idle ? 4'd0 : r_dx;
  assign w_dy = w_idle ? 4'd0 : r_dy;
  assign w_px = {3'b0, w_bx} + {8'b0, w_dx} - 12'(HALF);
  assign w_py = {3'b0, w_by} + {8'b0, w_dy} - 12'(HALF);
  assign w_in = !w_px[11] && !w_py[11] && w_px < 12'(DISPLAY_WIDTH) && w_py < 12'(DISPLAY_HEIGHT);
  assign w_addr = A'(w_py) * A'(DISPLAY_WIDTH) + A'(w_px);
  assign w_wrap = w_dx == 4'(BRUSH - 1);
  assign w_ndx = w_wrap ? 4'd0 : w_dx + 4'd1;
  assign w_ndy = w_wrap ? w_dy + 4'd1 : w_dy;
  assign w_accept = touch_valid && 32'(touch_x) < DISPLAY_WIDTH && 32'(touch_y) < DISPLAY_HEIGHT
                    && !(r_last_v && touch_x == r_last_x && touch_y == r_last_y);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt <= '0;
      r_last_v <= 1'b0;
      vram_wr_ena <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      busy <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_cnt == (A+1)'(VRAM_L)) begin
            r_state <= S_IDLE;
            vram_wr_ena <= 1'b0;
            busy <= 1'b0;
          end else begin
            vram_wr_ena <= 1'b1;
            vram_wr_addr <= r_cnt[A-1:0];
            vram_wr_data <= clear_color;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          vram_wr_ena <= 1'b0;
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_cnt <= '0;
            r_last_v <= 1'b0;
            busy <= 1'b1;
          end else if (w_accept) begin
            r_state <= S_PAINT;
            r_x <= touch_x;
            r_y <= touch_y;
            r_color <= draw_color;
            r_dx <= w_ndx;
            r_dy <= w_ndy;
            r_n <= 8'd1;
            busy <= 1'b1;
            vram_wr_ena <= w_in;
            vram_wr_addr <= w_in ? w_addr : '0;
            vram_wr_data <= draw_color;
          end
        end
        S_PAINT: begin
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_cnt <= '0;
            r_last_v <= 1'b0;
            vram_wr_ena <= 1'b0;
          end else if (r_n == 8'(N)) begin
            r_state <= S_IDLE;
            vram_wr_ena <= 1'b0;
            busy <= 1'b0;
            r_last_x <= r_x;
            r_last_y <= r_y;
            r_last_v <= 1'b1;
          end else begin
            r_dx <= w_ndx;
            r_dy <= w_ndy;
            r_n <= r_n + 8'd1;
            vram_wr_ena <= w_in;
            vram_wr_addr <= w_in ? w_addr : '0;
            vram_wr_data <= r_color;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vram_brush_writer.sv
// tb_vram_brush_writer: randomized touch/clear traffic against a per-cycle expected-write model on a small frame.
module tb_vram_brush_writer;
  localparam int W = 20, H = 12, B = 3, L = W * H, A = $clog2(L), HB = (B - 1) / 2;
  logic clk = 0, rst = 1, touch_valid = 0, clear_req = 0;
  logic [8:0] touch_x = 0, touch_y = 0;
  logic [15:0] clear_color = 0, draw_color = 0;
  logic vram_wr_ena, busy;
  logic [A-1:0] vram_wr_addr;
  logic [15:0] vram_wr_data;
  int n_chk = 0, n_fail = 0;
  bit last_v = 0;
  int last_x = 0, last_y = 0;
  always #5 clk = ~clk;
  vram_brush_writer #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .BRUSH(B)) dut (
    .clk(clk), .rst(rst), .touch_valid(touch_valid), .touch_x(touch_x), .touch_y(touch_y),
    .clear_req(clear_req), .clear_color(clear_color), .draw_color(draw_color),
    .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr), .vram_wr_data(vram_wr_data), .busy(busy));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] wr_obs();
    return vram_wr_ena ? {1'b1, 15'(vram_wr_addr), vram_wr_data} : 32'd0;
  endfunction
  function automatic logic [31:0] wr_exp(input bit e, input int a, input logic [15:0] d);
    return e ? {1'b1, 15'(a), d} : 32'd0;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_clear(input logic [15:0] col);
    for (int a = 0; a < L; a++) begin
      clear_req = 1'($urandom);
      touch_valid = 1'($urandom);
      touch_x = 9'($urandom_range(0, W - 1));
      touch_y = 9'($urandom_range(0, H - 1));
      step();
      chk("clear_wr", wr_obs(), wr_exp(1, a, col));
      chk("clear_busy", 32'(busy), 32'd1);
    end
    step();
    clear_req = 0;
    touch_valid = 0;
    chk("clear_done", {30'd0, busy, vram_wr_ena}, 32'd0);
    last_v = 0;
  endtask
  task automatic do_reset(input logic [15:0] col);
    clear_color = col;
    rst = 1;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_out", {vram_wr_ena, 15'(vram_wr_addr), vram_wr_data}, 32'd0);
    rst = 0;
    run_clear(col);
  endtask
  task automatic start_clear(input logic [15:0] col);
    clear_color = col;
    clear_req = 1;
    touch_valid = 1'($urandom);
    touch_x = 9'($urandom_range(0, W - 1));
    touch_y = 9'($urandom_range(0, H - 1));
    step();
    clear_req = 0;
    touch_valid = 0;
    chk("clear_start", {30'd0, busy, vram_wr_ena}, 32'd2);
    run_clear(col);
  endtask
  task automatic touch(input int x, input int y, input logic [15:0] c, input int abort_at);
    bit accept;
    int px, py;
    accept = x < W && y < H && !(last_v && x == last_x && y == last_y);
    touch_valid = 1;
    touch_x = 9'(x);
    touch_y = 9'(y);
    draw_color = c;
    step();
    touch_valid = 0;
    draw_color = 16'($urandom);
    if (!accept) begin
      for (int i = 0; i < 3; i++) begin
        chk("drop", {30'd0, busy, vram_wr_ena}, 32'd0);
        step();
      end
      return;
    end
    for (int i = 0; i < B * B; i++) begin
      px = x - HB + i % B;
      py = y - HB + i / B;
      chk("paint_wr", wr_obs(), wr_exp(px >= 0 && px < W && py >= 0 && py < H, py * W + px, c));
      chk("paint_busy", 32'(busy), 32'd1);
      if (i == B * B - 1) break;
      touch_valid = 1'($urandom);
      touch_x = 9'($urandom_range(0, W - 1));
      touch_y = 9'($urandom_range(0, H - 1));
      if (i + 1 == abort_at) begin
        clear_req = 1;
        step();
        clear_req = 0;
        touch_valid = 0;
        chk("abort", {30'd0, busy, vram_wr_ena}, 32'd2);
        run_clear(clear_color);
        return;
      end
      step();
    end
    step();
    touch_valid = 0;
    chk("paint_done", {30'd0, busy, vram_wr_ena}, 32'd0);
    last_v = 1;
    last_x = x;
    last_y = y;
  endtask
  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int r, x, y;
    do_reset(16'hFFFF);
    touch(10, 5, 16'h000F, -1);
    touch(0, 0, 16'h0A0A, -1);
    touch(W, 3, 16'h1111, -1);
    touch(10, 5, 16'h2222, -1);
    touch(10, 5, 16'h3333, -1);
    touch(W - 1, H - 1, 16'h4444, -1);
    start_clear(16'h1234);
    touch(W - 1, H - 1, 16'h5555, -1);
    touch(7, 7, 16'h6666, 4);
    touch(7, 7, 16'h7777, -1);
    clear_color = 16'hBEEF;
    clear_req = 1;
    step();
    clear_req = 0;
    repeat (50) step();
    do_reset(16'hCAFE);
    touch_valid = 1;
    touch_x = 9'd3;
    touch_y = 9'd3;
    step();
    touch_valid = 0;
    repeat (3) step();
    do_reset(16'h0F0F);
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 11);
      x = (r == 2) ? $urandom_range(0, 511) : $urandom_range(0, W + 2);
      y = (r == 3) ? $urandom_range(0, 511) : $urandom_range(0, H + 2);
      if (r == 4 && last_v) begin
        x = last_x;
        y = last_y;
      end
      if (r == 0) start_clear(16'($urandom));
      else touch(x, y, 16'($urandom), r == 1 ? $urandom_range(1, B * B - 1) : -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_brush_writer.md
VRAM_BRUSH_WRITER -- requirements
Module: vram_brush_writer

Interface
REQ-001 SHALL have parameter DISPLAY_WIDTH, default 240, pixels per row.
REQ-002 SHALL have parameter DISPLAY_HEIGHT, default 320, rows.
REQ-003 SHALL have parameter BRUSH, default 3, odd brush side length in pixels (1..15).
REQ-004 SHALL have localparam VRAM_L = DISPLAY_WIDTH*DISPLAY_HEIGHT and A = $clog2(VRAM_L) (17 at defaults).
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port touch_valid  input  1  touch sample is valid this cycle.
REQ-008 SHALL have port touch_x  input  9  touch column.
REQ-009 SHALL have port touch_y  input  9  touch row.
REQ-010 SHALL have port clear_req  input  1  single-cycle request to clear the frame.
REQ-011 SHALL have port clear_color  input  16  RGB565 fill colour.
REQ-012 SHALL have port draw_color  input  16  RGB565 brush colour.
REQ-013 SHALL have port vram_wr_ena  output  1  VRAM write strobe.
REQ-014 SHALL have port vram_wr_addr  output  A  VRAM address = row*DISPLAY_WIDTH + col.
REQ-015 SHALL have port vram_wr_data  output  16  VRAM write data.
REQ-016 SHALL have port busy  output  1  high in any state other than S_IDLE.

Function
REQ-017 SHALL implement states S_CLEAR, S_IDLE and S_PAINT.
REQ-018 SHALL drive all outputs from registers; no combinational path from inputs to outputs.
REQ-019 S_CLEAR SHALL write clear_color to addresses 0..VRAM_L-1 ascending, one per cycle, with vram_wr_ena high on every cycle, then enter S_IDLE with vram_wr_ena low.
REQ-020 S_CLEAR SHALL ignore clear_req and touch_valid.
REQ-021 In S_IDLE, clear_req SHALL move the block to S_CLEAR; clear_req SHALL take priority over a simultaneous touch_valid.
REQ-022 In S_IDLE, touch_valid with touch_x < DISPLAY_WIDTH and touch_y < DISPLAY_HEIGHT SHALL latch (x, y) and draw_color and enter S_PAINT, except as in REQ-023.
REQ-023 A touch equal to the last painted (x, y), since the last clear or reset, SHALL be dropped with no writes.
REQ-024 An out-of-range touch SHALL be dropped and SHALL leave the last-painted record unchanged.
REQ-025 S_PAINT SHALL run exactly BRUSH*BRUSH cycles over offsets dy, dx in 0..BRUSH-1, row-major with dx fastest.
REQ-026 For each S_PAINT cycle, the pixel SHALL be px = x - (BRUSH-1)/2 + dx and py = y - (BRUSH-1)/2 + dy.
REQ-027 S_PAINT coordinate arithmetic SHALL be signed, at least 11 bits wide.
REQ-028 For an in-bounds pixel, S_PAINT SHALL assert vram_wr_ena with vram_wr_addr = py*DISPLAY_WIDTH + px and vram_wr_data = the latched colour.
REQ-029 For an out-of-bounds pixel (px<0, py<0, px>=DISPLAY_WIDTH or py>=DISPLAY_HEIGHT), vram_wr_ena SHALL be low and the cycle SHALL still be consumed.
REQ-030 The first paint write SHALL appear on the cycle after the accepting touch sample.
REQ-031 After the last paint cycle, the block SHALL return to S_IDLE and record (x, y) as last painted.
REQ-032 touch_valid SHALL be ignored during S_PAINT.
REQ-033 clear_req during S_PAINT SHALL abort the brush and enter S_CLEAR on the next cycle, starting at address 0.
REQ-034 vram_wr_ena SHALL never be high for more than one address per cycle, and addresses SHALL never be >= VRAM_L.

Reset
REQ-035 While rst is high: vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=0, busy=1, last-painted record invalid, state=S_CLEAR with the clear counter at 0.
REQ-036 The first clear write (address 0) SHALL occur on the first cycle after rst falls.
REQ-037 Assertion of rst mid-clear or mid-paint SHALL restart the clear from address 0.

Verification
REQ-038 Reset release, clear_color=16'hFFFF -> 76800 consecutive writes, addr 0..76799, data FFFF; then busy=0 and wr_ena=0.
REQ-039 Touch (100,50), draw_color=16'h000F -> 9 writes over 9 cycles: 11859-11861, 12099-12101, 12339-12341; then busy falls.
REQ-040 Touch (0,0) -> busy for 9 cycles; writes only to addrs 0, 1, 240, 241.
REQ-041 Touch (240,10), then (100,50) twice -> first is dropped; second paints 9 pixels; third produces no writes and busy stays 0.
REQ-042 clear_req on paint cycle 4 -> no further paint writes; full clear runs from addr 0; a subsequent touch at the previously painted point repaints.
REQ-043 rst pulsed at clear address 5000 -> next write is address 0.
